// File: rtl/tank_sprite_server.sv
// Tank sprite store: streams one up-facing RGB444 image into RAM, then serves
// pixels in any of four orientations that are committed at the vsync rising edge.
module tank_sprite_server #(
    parameter int          SPR_W       = 48,
    parameter int          SPR_H       = 64,
    parameter logic [11:0] TRANSPARENT = 12'hFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] pixel_addr,
    input  logic [1:0]  direction_tank,
    input  logic        vsync_in,
    input  logic        reload,
    input  logic        load_valid,
    input  logic [11:0] load_data,
    input  logic        load_last,
    output logic        load_ready,
    output logic        sprite_ready,
    output logic        load_err,
    output logic [11:0] rgb_pixel
);
    // state   | meaning
    // EMPTY   | no image held, pointer at 0, waiting for the first beat
    // LOADING | image partially written, pointer advancing per beat
    // READY   | full image stored, loading closed, reads enabled
    typedef enum logic [1:0] {EMPTY, LOADING, READY} state_t;
    typedef enum logic [1:0] {ORI_UP, ORI_DOWN, ORI_LEFT, ORI_RIGHT} ori_t;

    localparam int          DEPTH    = SPR_W * SPR_H;
    localparam logic [11:0] LAST_IDX = 12'(DEPTH - 1);
    localparam logic [6:0]  W_LIM    = 7'(SPR_W);
    localparam logic [6:0]  H_LIM    = 7'(SPR_H);
    localparam logic [5:0]  W_MAX    = 6'(SPR_W - 1);
    localparam logic [5:0]  H_MAX    = 6'(SPR_H - 1);

    logic [11:0] mem [0:DEPTH-1];

    state_t      state_q, state_d;
    logic [11:0] wr_ptr_q, wr_ptr_d;
    logic        load_err_q, load_err_d;
    logic        load_ready_q, load_ready_d;
    logic        sprite_ready_q, sprite_ready_d;
    logic        vsync_q, vsync_d;
    ori_t        ori_q, ori_d;
    logic        hit_q, hit_d;
    logic [11:0] rd_data_q;

    logic        beat_acc;
    logic        ptr_end;
    logic [5:0]  ax, ay, sx, sy;
    logic        in_range;
    logic        rd_en;
    logic [11:0] rd_idx;

    assign beat_acc = load_valid & load_ready_q & ~reload;
    assign ptr_end  = (wr_ptr_q == LAST_IDX);
    assign ax       = pixel_addr[5:0];
    assign ay       = pixel_addr[11:6];

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        load_err_d = load_err_q;
        if (reload) begin
            state_d    = EMPTY;
            wr_ptr_d   = '0;
            load_err_d = 1'b0;
        end else if (beat_acc) begin
            load_err_d = 1'b0;
            if (ptr_end && load_last) begin
                state_d  = READY;
                wr_ptr_d = '0;
            end else if (ptr_end || load_last) begin
                state_d    = EMPTY;
                wr_ptr_d   = '0;
                load_err_d = 1'b1;
            end else begin
                state_d  = LOADING;
                wr_ptr_d = wr_ptr_q + 12'd1;
            end
        end
        load_ready_d   = (state_d != READY);
        sprite_ready_d = (state_d == READY);
        vsync_d        = vsync_in;
        ori_d          = (vsync_in && !vsync_q) ? ori_t'(direction_tank) : ori_q;
    end

    // Screen offset -> stored (sx, sy); left/right swap the bounding box to 64x48.
    always_comb begin
        in_range = 1'b0;
        sx       = ax;
        sy       = ay;
        case (ori_q)
            ORI_UP: begin
                in_range = ({1'b0, ax} < W_LIM) && ({1'b0, ay} < H_LIM);
                sx = ax;
                sy = ay;
            end
            ORI_DOWN: begin
                in_range = ({1'b0, ax} < W_LIM) && ({1'b0, ay} < H_LIM);
                sx = W_MAX - ax;
                sy = H_MAX - ay;
            end
            ORI_LEFT: begin
                in_range = ({1'b0, ax} < H_LIM) && ({1'b0, ay} < W_LIM);
                sx = W_MAX - ay;
                sy = ax;
            end
            ORI_RIGHT: begin
                in_range = ({1'b0, ax} < H_LIM) && ({1'b0, ay} < W_LIM);
                sx = ay;
                sy = H_MAX - ax;
            end
            default: in_range = 1'b0;
        endcase
        rd_idx = ({6'd0, sy} << 5) + ({6'd0, sy} << 4) + {6'd0, sx};
        rd_en  = in_range && (state_q == READY);
        hit_d  = rd_en;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= EMPTY;
            wr_ptr_q       <= '0;
            load_err_q     <= 1'b0;
            load_ready_q   <= 1'b1;
            sprite_ready_q <= 1'b0;
            vsync_q        <= 1'b0;
            ori_q          <= ORI_UP;
            hit_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            load_err_q     <= load_err_d;
            load_ready_q   <= load_ready_d;
            sprite_ready_q <= sprite_ready_d;
            vsync_q        <= vsync_d;
            ori_q          <= ori_d;
            hit_q          <= hit_d;
        end
    end

    // Reads are only enabled in READY, when no write can be in flight.
    always_ff @(posedge clk) begin
        if (beat_acc) mem[wr_ptr_q] <= load_data;
        if (rd_en)    rd_data_q     <= mem[rd_idx];
    end

    assign load_ready   = load_ready_q;
    assign sprite_ready = sprite_ready_q;
    assign load_err     = load_err_q;
    assign rgb_pixel    = hit_q ? rd_data_q : TRANSPARENT;

endmodule

// File: tb/tb_tank_sprite_server.sv
// Scoreboard bench for tank_sprite_server: driver pushes expected pixels from a
// geometric reference model, a monitor pops them one cycle after each read.
module tb_tank_sprite_server;
    localparam logic [11:0] TRANSP = 12'hFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] pixel_addr = '0;
    logic [1:0]  direction_tank = 2'd0;
    logic        vsync_in = 1'b0;
    logic        reload = 1'b0;
    logic        load_valid = 1'b0;
    logic [11:0] load_data = '0;
    logic        load_last = 1'b0;
    logic        load_ready;
    logic        sprite_ready;
    logic        load_err;
    logic [11:0] rgb_pixel;

    tank_sprite_server dut (
        .clk(clk), .rst(rst), .pixel_addr(pixel_addr), .direction_tank(direction_tank),
        .vsync_in(vsync_in), .reload(reload), .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_ready(load_ready), .sprite_ready(sprite_ready),
        .load_err(load_err), .rgb_pixel(rgb_pixel)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [11:0] exp_q[$];
    string       tag_q[$];
    logic        rd_req = 1'b0;
    logic        rd_pend = 1'b0;

    // Reference model: the stored image, beats since EMPTY, flags, orientation.
    logic [11:0] m_img [3072];
    bit          m_ready = 0;
    bit          m_err = 0;
    int          m_cnt = 0;
    logic [1:0]  m_ori = 2'd0;

    task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic chk_bit(input string nm, input logic act, input logic exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %b expected %b", nm, act, exp);
    endtask

    task automatic chk_status(input string nm);
        chk_bit({nm, "_load_ready"}, load_ready, !m_ready);
        chk_bit({nm, "_sprite_ready"}, sprite_ready, m_ready);
        chk_bit({nm, "_load_err"}, load_err, m_err);
    endtask

    function automatic logic [11:0] exp_pix(input logic [11:0] a);
        int ax, ay, sx, sy;
        bit inr;
        ax = int'(a[5:0]);
        ay = int'(a[11:6]);
        if (!m_ready) return TRANSP;
        case (m_ori)
            2'd0: begin inr = (ax < 48); sx = ax;      sy = ay;      end
            2'd1: begin inr = (ax < 48); sx = 47 - ax; sy = 63 - ay; end
            2'd2: begin inr = (ay < 48); sx = 47 - ay; sy = ax;      end
            default: begin inr = (ay < 48); sx = ay;   sy = 63 - ax; end
        endcase
        if (!inr) return TRANSP;
        return m_img[sy * 48 + sx];
    endfunction

    function automatic void m_beat(input logic [11:0] d, input logic last);
        if (m_ready) return;
        m_img[m_cnt] = d;
        if (m_cnt == 3071 && last) begin
            m_ready = 1; m_cnt = 0; m_err = 0;
        end else if (m_cnt == 3071 || last) begin
            m_err = 1; m_cnt = 0;
        end else begin
            m_cnt++; m_err = 0;
        end
    endfunction

    function automatic void m_clear();
        m_ready = 0; m_err = 0; m_cnt = 0;
    endfunction

    task automatic beat(input logic [11:0] d, input logic last, input bit bubbles);
        if (bubbles && $urandom_range(0, 3) == 0) begin
            @(negedge clk);
            load_valid = 1'b0;
            load_last  = 1'b0;
        end
        @(negedge clk);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        m_beat(d, last);
    endtask

    task automatic end_beats();
        @(negedge clk);
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic reload_pulse(input bit with_beat);
        @(negedge clk);
        reload = 1'b1;
        if (with_beat) begin
            load_valid = 1'b1;
            load_data  = 12'hABC;
            load_last  = 1'b0;
        end
        @(negedge clk);
        reload     = 1'b0;
        load_valid = 1'b0;
        m_clear();
    endtask

    // Commit d at a vsync rising edge, then wiggle direction_tank mid-frame.
    task automatic commit(input logic [1:0] d);
        @(negedge clk);
        direction_tank = d;
        vsync_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        direction_tank = ~d;
        @(negedge clk);
        vsync_in = 1'b0;
        m_ori = d;
        @(negedge clk);
    endtask

    task automatic rd_exp(input logic [11:0] a, input logic [11:0] e, input string nm);
        @(negedge clk);
        pixel_addr = a;
        rd_req = 1'b1;
        exp_q.push_back(e);
        tag_q.push_back(nm);
        @(negedge clk);
        rd_req = 1'b0;
        pixel_addr = 12'($urandom);
    endtask

    task automatic rd_rand(input int n);
        logic [11:0] a;
        for (int i = 0; i < n; i++) begin
            a = 12'($urandom);
            rd_exp(a, exp_pix(a), "rand_rd");
        end
    endtask

    always @(posedge clk) rd_pend <= rd_req;

    always @(negedge clk) begin
        if (rd_pend) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL sb_underflow: got pixel %h expected no read", rgb_pixel);
            end else begin
                chk(tag_q.pop_front(), rgb_pixel, exp_q.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk_status("reset");
        chk("reset_rgb", rgb_pixel, TRANSP);
        rst = 1'b1;

        rd_rand(6);

        for (int i = 0; i <= 100; i++) beat(12'(i), i == 100, 0);
        end_beats();
        chk_status("short_load");
        chk_bit("short_load_err", load_err, 1'b1);
        beat(12'h123, 1'b0, 0);
        end_beats();
        chk_status("err_clear");
        reload_pulse(0);
        chk_status("reload_empty");

        for (int i = 0; i < 2000; i++) beat(12'(i), 1'b0, 1);
        @(negedge clk);
        load_valid = 1'b0;
        rst = 1'b0;
        m_clear();
        m_ori = 2'd0;
        #1;
        chk_status("rst_mid_load");
        chk("rst_mid_rgb", rgb_pixel, TRANSP);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 2000; i < 3072; i++) beat(12'(i), i == 3071, 0);
        end_beats();
        chk_status("after_abort");

        reload_pulse(1);
        chk_status("reload_beat");
        for (int i = 0; i < 3072; i++) beat(12'(i), i == 3071, 0);
        end_beats();
        chk_bit("full_sprite_ready", sprite_ready, 1'b1);
        chk_bit("full_load_ready", load_ready, 1'b0);
        chk_status("full_load");

        rd_exp({6'd1, 6'd2}, 12'd50, "up_1_2");
        rd_exp({6'd0, 6'd48}, TRANSP, "up_oor");
        rd_rand(20);

        @(negedge clk);
        direction_tank = 2'd1;
        rd_exp({6'd0, 6'd0}, 12'd0, "no_vsync_edge");
        commit(2'd1);
        rd_exp({6'd0, 6'd0}, 12'd3071, "down_0_0");
        rd_rand(20);
        commit(2'd2);
        rd_exp({6'd0, 6'd0}, 12'd47, "left_0_0");
        rd_exp({6'd48, 6'd0}, TRANSP, "left_oor");
        rd_rand(20);
        commit(2'd3);
        rd_exp({6'd0, 6'd0}, 12'd3024, "right_0_0");
        rd_rand(20);

        reload_pulse(0);
        chk_status("reload_ready");
        rd_rand(4);

        for (int i = 0; i < 3072; i++) beat(12'($urandom), i == 3071, 1);
        end_beats();
        chk_status("rand_load");
        for (int k = 0; k < 4; k++) begin
            commit(2'($urandom_range(0, 3)));
            rd_rand(15);
        end

        repeat (3) @(negedge clk);
        chk("sb_drain", 12'(exp_q.size()), 12'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/tank_sprite_server.md
TANK_SPRITE_SERVER -- requirements
Module: tank_sprite_server

Interface
REQ-001 Parameters SHALL be: SPR_W, default 48, stored sprite width in pixels; SPR_H, default 64, stored sprite height in pixels; TRANSPARENT, default 12'hFFF, colour returned for "no pixel".
REQ-002 Ports SHALL be:
- clk, input, 1, system clock; the block has exactly one clock.
- rst, input, 1, reset, asynchronous and active-low.
- pixel_addr, input, 12, read request {ay[5:0], ax[5:0]}, offset of the beam from the tank origin.
- direction_tank, input, 2, requested orientation: 0 up, 1 down, 2 left, 3 right.
- vsync_in, input, 1, frame sync; its rising edge is the orientation commit point.
- reload, input, 1, one-cycle pulse that discards the sprite and re-arms loading.
- load_valid, input, 1, load beat present.
- load_data, input, 12, load pixel in RGB444.
- load_last, input, 1, marks the final beat of an image.
- load_ready, output, 1, block accepts a beat this cycle.
- sprite_ready, output, 1, a complete image is stored.
- load_err, output, 1, sticky flag for a malformed load.
- rgb_pixel, output, 12, sprite colour for the pixel_addr presented one cycle earlier.

Function
REQ-003 Storage SHALL be SPR_W*SPR_H (3072) words x 12 bits, holding the up-facing image in row-major order: word index = sy*48+sx.
REQ-004 The load FSM SHALL have states EMPTY, LOADING and READY.
REQ-005 load_ready SHALL be 1 in EMPTY and LOADING, and 0 in READY; a beat is accepted when load_valid and load_ready are both 1.
REQ-006 Each accepted beat SHALL write load_data at the write pointer, then increment the pointer; the pointer SHALL be 0 on entry to EMPTY.
REQ-007 EMPTY SHALL move to LOADING on the first accepted beat, unless that beat also ends the load (REQ-008/009).
REQ-008 A beat accepted with pointer 3071 and load_last=1 SHALL move the FSM to READY.
REQ-009 A beat accepted with load_last=1 and pointer<3071, or with pointer 3071 and load_last=0, SHALL set load_err and return the FSM to EMPTY.
REQ-010 load_err SHALL clear on a reload pulse or on the first accepted beat of the next load.
REQ-011 A reload pulse SHALL force EMPTY from any state; reload SHALL win over a simultaneous beat, and that beat is not written.
REQ-012 sprite_ready SHALL be 1 only in READY.
REQ-013 The active orientation SHALL update from direction_tank only on the clock following a detected 0->1 transition of vsync_in; mid-frame changes SHALL have no visible effect.
REQ-014 Address mapping (ax = pixel_addr[5:0], ay = pixel_addr[11:6]):
- up: in range when ax<48 and ay<64; sx=ax, sy=ay.
- down: in range when ax<48 and ay<64; sx=47-ax, sy=63-ay.
- left: in range when ax<64 and ay<48; sx=47-ay, sy=ax.
- right: in range when ax<64 and ay<48; sx=ay, sy=63-ax.
REQ-015 The word index SHALL be formed as sy*32+sy*16+sx using shift-add only, 12 bits wide, with no wrap for in-range coordinates.
REQ-016 rgb_pixel SHALL have exactly 1-cycle latency: a synchronous RAM read, plus a registered in-range flag and a registered sprite_ready.
REQ-017 rgb_pixel SHALL be TRANSPARENT when the registered request was out of range or sprite_ready was 0 at sampling.
REQ-018 Reads SHALL never alias onto writes, because reads are masked whenever the FSM is not in READY.

Reset
REQ-019 On rst=0, asynchronously: FSM=EMPTY, pointer=0, load_err=0, sprite_ready=0, load_ready=1, rgb_pixel=TRANSPARENT, active orientation=up, vsync history=0; RAM contents are not cleared.
REQ-020 Reset asserted during LOADING SHALL abandon the partial image; a full reload is then required before sprite_ready returns to 1.

Verification
REQ-021 Load 3072 beats of data = index[11:0], last on beat 3071 -> sprite_ready=1 and load_ready=0 the cycle after; up, addr {6'd1,6'd2} -> rgb_pixel=12'd50 one cycle later.
REQ-022 Same image, commit down at a vsync edge, addr {6'd0,6'd0} -> 12'd3071; commit left, addr {6'd0,6'd0} -> 12'd47; commit right, addr {6'd0,6'd0} -> 12'd3024.
REQ-023 Orientation change without a vsync edge -> the mapping is unchanged; after the vsync 0->1 edge -> the new mapping applies from the next clock.
REQ-024 up, addr {6'd0,6'd48} and left, addr {6'd48,6'd0} -> TRANSPARENT; before any load, any addr -> TRANSPARENT.
REQ-025 load_last on beat 100 -> load_err=1, FSM=EMPTY, sprite_ready=0; the next accepted beat clears load_err.
REQ-026 rst pulsed low at beat 2000 -> all outputs at reset values immediately; reload pulse with a simultaneous beat -> EMPTY, pointer=0, beat discarded.
